// File: rtl/pdm_rec_play_ctrl.sv
// rtl/pdm_rec_play_ctrl.sv - PDM mic record / amplifier playback sequencer owning the sample RAM port
// Build option: define PLAY_LOOP_EN to repeat playback while the play button stays held.
module pdm_rec_play_ctrl #(
    parameter int CLK_DIV = 25,
    parameter int ADDR_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec,
    input  logic              play,
    input  logic              data_in,
    output logic              bclk,
    output logic              lrsel,
    output logic              data_out,
    output logic              ampSD,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W:0]   rec_len,
    output logic              busy
);
    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              bclk_q, bclk_d;
    logic              rec_s1_q, rec_s1_d;
    logic              rec_s2_q, rec_s2_d;
    logic              rec_prev_q, rec_prev_d;
    logic              play_s1_q, play_s1_d;
    logic              play_s2_q, play_s2_d;
    logic              play_prev_q, play_prev_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              load_q, load_d;
    logic              data_out_q, data_out_d;
    logic              amp_q, amp_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;

    logic              div_wrap;
    logic              rise_tick;
    logic              fall_tick;
    logic              rec_rise;
    logic              play_rise;
    logic              more_bytes;
    logic              end_play;
    logic [ADDR_W:0]   next_addr;

    always_comb begin
        div_wrap   = (div_cnt_q == DIV_LAST);
        rise_tick  = div_wrap && !bclk_q;
        fall_tick  = div_wrap && bclk_q;
        rec_rise   = rec_s2_q && !rec_prev_q;
        play_rise  = play_s2_q && !play_prev_q;
        next_addr  = {1'b0, mem_addr_q} + LEN_ONE;
        more_bytes = (next_addr < rec_len_q);
        end_play   = 1'b0;

        state_d     = state_q;
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + DIV_ONE;
        bclk_d      = div_wrap ? !bclk_q : bclk_q;
        rec_s1_d    = rec;
        rec_s2_d    = rec_s1_q;
        rec_prev_d  = rec_s2_q;
        play_s1_d   = play;
        play_s2_d   = play_s1_q;
        play_prev_d = play_s2_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        load_d      = rd_q;
        data_out_d  = data_out_q;
        amp_d       = amp_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rec_len_d   = rec_len_q;

        unique case (state_q)
            ST_IDLE: begin
                // Record beats play when both buttons rise together.
                if (rec_rise) begin
                    state_d    = ST_REC;
                    mem_addr_d = '0;
                    bit_cnt_d  = '0;
                    rec_len_d  = '0;
                end else if (play_rise && (rec_len_q != '0)) begin
                    state_d    = ST_PLAY;
                    mem_addr_d = '0;
                    bit_cnt_d  = '0;
                    rd_d       = 1'b1;
                    amp_d      = 1'b1;
                end
            end
            ST_REC: begin
                if (wr_q) begin
                    rec_len_d = rec_len_q + LEN_ONE;
                    if (mem_addr_q == ADDR_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_ONE;
                    end
                end else if (rise_tick) begin
                    shift_d = {shift_q[6:0], data_in};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = '0;
                        if (rec_s2_q) begin
                            wr_d        = 1'b1;
                            mem_wdata_d = {shift_q[6:0], data_in};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PLAY: begin
                // Shift register holds the not-yet-emitted bits left-aligned.
                if (load_q) begin
                    shift_d    = {mem_rdata[6:0], 1'b0};
                    data_out_d = mem_rdata[7];
                    bit_cnt_d  = 4'd1;
                end else if (fall_tick && !rd_q) begin
                    if (bit_cnt_q != 4'd8) begin
                        data_out_d = shift_q[7];
                        shift_d    = {shift_q[6:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end else begin
`ifdef PLAY_LOOP_EN
                        if (!play_s2_q) begin
                            end_play = 1'b1;
                        end else begin
                            rd_d       = 1'b1;
                            mem_addr_d = more_bytes ? mem_addr_q + ADDR_ONE : '0;
                        end
`else
                        if (more_bytes) begin
                            rd_d       = 1'b1;
                            mem_addr_d = mem_addr_q + ADDR_ONE;
                        end else begin
                            end_play = 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (end_play) begin
            state_d    = ST_IDLE;
            amp_d      = 1'b0;
            data_out_d = 1'b0;
            bit_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            rec_s1_q    <= 1'b0;
            rec_s2_q    <= 1'b0;
            rec_prev_q  <= 1'b0;
            play_s1_q   <= 1'b0;
            play_s2_q   <= 1'b0;
            play_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            load_q      <= 1'b0;
            data_out_q  <= 1'b0;
            amp_q       <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rec_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bclk_q      <= bclk_d;
            rec_s1_q    <= rec_s1_d;
            rec_s2_q    <= rec_s2_d;
            rec_prev_q  <= rec_prev_d;
            play_s1_q   <= play_s1_d;
            play_s2_q   <= play_s2_d;
            play_prev_q <= play_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            load_q      <= load_d;
            data_out_q  <= data_out_d;
            amp_q       <= amp_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rec_len_q   <= rec_len_d;
        end
    end

    assign bclk      = bclk_q;
    assign lrsel     = 1'b0;
    assign data_out  = data_out_q;
    assign ampSD     = amp_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rec_len   = rec_len_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pdm_rec_play_ctrl.sv
// tb/tb_pdm_rec_play_ctrl.sv - scoreboard bench for pdm_rec_play_ctrl with a synchronous RAM model
`timescale 1ns/1ps
module tb_pdm_rec_play_ctrl;
    localparam int CLK_DIV = 2;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rec;
    logic              play;
    logic              data_in;
    logic              bclk;
    logic              lrsel;
    logic              data_out;
    logic              ampSD;
    logic              wr;
    logic              rd;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = 8'h00;
    logic [ADDR_W:0]   rec_len;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_exp_t;

    wr_exp_t           exp_wr[$];
    logic [ADDR_W-1:0] exp_rd[$];
    logic              exp_bit[$];

    logic [7:0] ram  [0:(1<<ADDR_W)-1];
    logic [7:0] stim [0:19];

    int   checks   = 0;
    int   errors   = 0;
    int   wr_count = 0;
    int   rd_count = 0;
    int   pb       = 0;
    logic rd_p1    = 1'b0;
    logic rd_p2    = 1'b0;
    logic bclk_p   = 1'b0;

    pdm_rec_play_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rec       (rec),
        .play      (play),
        .data_in   (data_in),
        .bclk      (bclk),
        .lrsel     (lrsel),
        .data_out  (data_out),
        .ampSD     (ampSD),
        .wr        (wr),
        .rd        (rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rec_len   (rec_len),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (wr) ram[mem_addr] <= mem_wdata;
        if (rd) mem_rdata <= ram[mem_addr];
    end

    task automatic sample_bit();
        chk("bit_expected", 32'(exp_bit.size() != 0), 32'd1);
        if (exp_bit.size() != 0) begin
            chk("play_bit", 32'(data_out), 32'(exp_bit.pop_front()));
            chk("amp_on", 32'(ampSD), 32'd1);
        end
    endtask

    // A played bit starts two samples after rd, then at each bclk fall; the 8th fall ends the byte.
    always @(negedge clk) begin
        logic    load_evt;
        logic    fall_evt;
        wr_exp_t e;
        load_evt = rd_p2;
        fall_evt = bclk_p && !bclk;
        rd_p2    = rd_p1;
        rd_p1    = rd;
        bclk_p   = bclk;
        if (!reset) begin
            pb    = 0;
            rd_p1 = 1'b0;
            rd_p2 = 1'b0;
        end else begin
            if (wr) begin
                wr_count++;
                chk("wr_rd_excl", 32'(rd), 32'd0);
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (rd) begin
                rd_count++;
                chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) chk("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
            if (load_evt) begin
                sample_bit();
                pb = 1;
            end else if (fall_evt) begin
                if (pb >= 1 && pb < 8) begin
                    sample_bit();
                    pb++;
                end else if (pb == 8) begin
                    pb = 0;
                end
            end
        end
    end

    task automatic wait_busy(input logic val, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max_cyc && !ok; n++) begin
            @(posedge clk);
            #1;
            if (busy == val) ok = 1'b1;
        end
    endtask

    task automatic wait_bclk_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int n = 0; n < 4 * CLK_DIV + 4 && !ok; n++) begin
            prev = bclk;
            @(posedge clk);
            #1;
            if (!prev && bclk) ok = 1'b1;
        end
    endtask

    task automatic rec_session(input int n_bytes, input int release_bit, input int n_wr);
        bit ok;
        rec = 1'b1;
        wait_busy(1'b1, 10, ok);
        chk("rec_enter", 32'(ok), 32'd1);
        for (int i = 0; i < n_bytes * 8; i++) begin
            logic [7:0] b;
            b = stim[i / 8];
            if (i == release_bit) rec = 1'b0;
            data_in = b[7 - (i % 8)];
            if ((i % 8 == 7) && (i / 8 < n_wr)) exp_wr.push_back('{addr: ADDR_W'(i / 8), data: b});
            wait_bclk_rise(ok);
            if (!ok) begin
                chk("bclk_running", 32'(ok), 32'd1);
                break;
            end
            if (!busy) break;
        end
    endtask

    task automatic play_session(input int len, input int n_rd);
        bit ok;
        int base;
        base = rd_count;
        for (int i = 0; i < n_rd; i++) begin
            exp_rd.push_back(ADDR_W'(i % len));
            for (int k = 7; k >= 0; k--) exp_bit.push_back(stim[i % len][k]);
        end
        play = 1'b1;
        ok   = 1'b0;
        for (int n = 0; n < 4000 && !ok; n++) begin
            @(posedge clk);
            #1;
            if (rd_count >= base + n_rd) ok = 1'b1;
        end
        chk("rd_seen", 32'(rd_count - base), 32'(n_rd));
        play = 1'b0;
        wait_busy(1'b0, 200, ok);
        chk("play_exit", 32'(ok), 32'd1);
        chk("play_amp_off", 32'(ampSD), 32'd0);
        chk("play_dout_off", 32'(data_out), 32'd0);
        chk("play_bits_left", 32'(exp_bit.size()), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_rd", 32'(rd_count - base), 32'(n_rd));
    endtask

    initial begin
        bit   ok;
        logic v;
        int   base_rd;
        int   base_wr;

        reset   = 1'b0;
        rec     = 1'b0;
        play    = 1'b0;
        data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_amp", 32'(ampSD), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_len", 32'(rec_len), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lrsel", 32'(lrsel), 32'd0);
        reset = 1'b1;

        v  = bclk;
        ok = 1'b0;
        for (int n = 0; n < 2 * CLK_DIV + 2 && !ok; n++) begin
            @(negedge clk);
            if (bclk != v) ok = 1'b1;
        end
        chk("bclk_first_toggle", 32'(ok), 32'd1);
        v = bclk;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("bclk_period", 32'(bclk), 32'(v ^ ((i / CLK_DIV) % 2 == 1)));
        end
        @(posedge clk);
        #1;

        stim[0] = 8'hA5;
        stim[1] = 8'h3C;
        stim[2] = 8'hFF;
        stim[3] = 8'h81;
        stim[4] = 8'h00;
        rec_session(5, 26, 3);
        wait_busy(1'b0, 100, ok);
        chk("rec3_exit", 32'(ok), 32'd1);
        chk("rec3_len", 32'(rec_len), 32'd3);
        chk("rec3_wr_count", 32'(wr_count), 32'd3);
        chk("rec3_wr_left", 32'(exp_wr.size()), 32'd0);

        play_session(3, 3);

        for (int i = 0; i < 20; i++) stim[i] = 8'(i * 37 + 11);
        base_wr = wr_count;
        rec_session(20, -1, 16);
        chk("full_idle_rec_high", 32'(busy), 32'd0);
        chk("full_len", 32'(rec_len), 32'd16);
        chk("full_wr_count", 32'(wr_count - base_wr), 32'd16);
        chk("full_addr_hold", 32'(mem_addr), 32'd15);
        chk("full_wr_left", 32'(exp_wr.size()), 32'd0);
        rec = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        base_rd = rd_count;
        base_wr = wr_count;
        rec  = 1'b1;
        play = 1'b1;
        wait_busy(1'b1, 10, ok);
        chk("prio_busy", 32'(ok), 32'd1);
        chk("prio_rec_amp", 32'(ampSD), 32'd0);
        play = 1'b0;
        repeat (6) @(posedge clk);
        play = 1'b1;
        repeat (6) @(posedge clk);
        play = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rec = 1'b0;
        wait_busy(1'b0, 40 * CLK_DIV, ok);
        chk("prio_exit", 32'(ok), 32'd1);
        chk("prio_no_wr", 32'(wr_count - base_wr), 32'd0);
        chk("prio_no_rd", 32'(rd_count - base_rd), 32'd0);
        chk("prio_len", 32'(rec_len), 32'd0);
        play = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("empty_play_busy", 32'(busy), 32'd0);
        chk("empty_play_amp", 32'(ampSD), 32'd0);
        chk("empty_play_rd", 32'(rd_count - base_rd), 32'd0);
        play = 1'b0;
        repeat (4) @(posedge clk);
        #1;

`ifdef PLAY_LOOP_EN
        stim[0] = 8'h96;
        stim[1] = 8'h4B;
        stim[2] = 8'hE7;
        rec_session(3, 18, 2);
        wait_busy(1'b0, 100, ok);
        chk("loop_rec_exit", 32'(ok), 32'd1);
        chk("loop_len", 32'(rec_len), 32'd2);
        play_session(2, 4);
`endif

        rec = 1'b1;
        wait_busy(1'b1, 10, ok);
        chk("mid_rec_enter", 32'(ok), 32'd1);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_len", 32'(rec_len), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_bclk", 32'(bclk), 32'd0);
        chk("mid_wr", 32'(wr), 32'd0);
        rec = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        base_rd = rd_count;
        play    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_play_no_rd", 32'(rd_count - base_rd), 32'd0);
        chk("mid_play_amp", 32'(ampSD), 32'd0);
        play = 1'b0;

        chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);
        chk("sb_bit_empty", 32'(exp_bit.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
